// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // The step counter never collapses to zero bits, even for a single-step operation.
  function automatic int cnt_width(input int n_steps);
    return (n_steps <= 2) ? 1 : $clog2(n_steps);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used to build the per-cycle ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: BITS_PER_CYCLE bits per cycle, LSB first, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(STEPS);

  if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_chk
    $fatal(1, "serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, ovf_q;

  logic [B-1:0]     chain_s;
  logic [B:0]       chain_c;
  logic [WIDTH-1:0] res_d;
  logic             accept, last_step;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(STEPS - 1));

  assign chain_c[0] = carry_q;
  for (genvar i = 0; i < B; i++) begin : g_chain
    full_adder u_fa (
      .a    (opa_q[i]),
      .b    (opb_q[i]),
      .cin  (chain_c[i]),
      .s    (chain_s[i]),
      .cout (chain_c[i+1])
    );
  end

  // New sum bits enter at the MSB end so the LSB-first slices land in place after STEPS shifts.
  assign res_d = (res_q >> B) | (WIDTH'(chain_s) << (WIDTH - B));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      opa_q   <= a;
      opb_q   <= sub ? ~b : b;
      carry_q <= sub | cin;
      cnt_q   <= '0;
      res_q   <= '0;
    end else if (state_q == RUN) begin
      opa_q   <= opa_q >> B;
      opb_q   <= opb_q >> B;
      res_q   <= res_d;
      carry_q <= chain_c[B];
      cnt_q   <= cnt_q + 1'b1;
      // Result outputs only change here, so they hold through DONE and the following IDLE.
      if (last_step) begin
        sum_q  <= res_d;
        cout_q <= chain_c[B];
        ovf_q  <= chain_c[B-1] ^ chain_c[B];
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at 1, 4 and 8 bits per cycle against an arithmetic reference model.
module tb_serial_adder;

  localparam int NI = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0] iv, ordy, ir, ov, bz, co, of;
  logic [W-1:0]  a, b;
  logic          sub, cin;
  logic [W-1:0]  sm [NI];

  int checks = 0;
  int errors = 0;
  int steps_of [NI] = '{8, 2, 1};

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]), .ovf(of[0]), .busy(bz[0]));
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]), .ovf(of[1]), .busy(bz[1]));
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_b8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]), .cout(co[2]), .ovf(of[2]), .busy(bz[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic on the operands.
  function automatic void ref_op(input logic [7:0] ra, input logic [7:0] rb, input logic rsub,
                                 input logic rcin, output logic [7:0] s, output logic c, output logic v);
    int ua, ub, ci, r, sa, sb, sr;
    ua = ra; ub = rb; ci = rcin;
    sa = $signed(ra); sb = $signed(rb);
    if (rsub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + ci;
      c  = (r > 255);
      sr = sa + sb + ci;
    end
    s = r[7:0];
    v = (sr > 127) || (sr < -128);
  endfunction

  // Model: 0 idle, 1 computing (countdown), 2 result held.
  int         m_phase [NI];
  int         m_left  [NI];
  logic [7:0] m_sum [NI], p_sum [NI];
  logic       m_cout [NI], m_ovf [NI], p_cout [NI], p_ovf [NI];

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] ts;
    logic       tc, tv;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_phase[k] <= 0; m_left[k] <= 0;
        m_sum[k] <= '0; m_cout[k] <= 1'b0; m_ovf[k] <= 1'b0;
        p_sum[k] <= '0; p_cout[k] <= 1'b0; p_ovf[k] <= 1'b0;
      end else begin
        case (m_phase[k])
          0: if (iv[k]) begin
               ref_op(a, b, sub, cin, ts, tc, tv);
               p_sum[k] <= ts; p_cout[k] <= tc; p_ovf[k] <= tv;
               m_phase[k] <= 1; m_left[k] <= steps_of[k];
             end
          1: begin
               m_left[k] <= m_left[k] - 1;
               if (m_left[k] == 1) begin
                 m_phase[k] <= 2;
                 m_sum[k] <= p_sum[k]; m_cout[k] <= p_cout[k]; m_ovf[k] <= p_ovf[k];
               end
             end
          default: if (ordy[k]) m_phase[k] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("cyc.in_ready[%0d]", k),  ir[k], m_phase[k] == 0);
      chk($sformatf("cyc.busy[%0d]", k),      bz[k], m_phase[k] == 1);
      chk($sformatf("cyc.out_valid[%0d]", k), ov[k], m_phase[k] == 2);
      chk($sformatf("cyc.sum[%0d]", k),       sm[k], m_sum[k]);
      chk($sformatf("cyc.cout[%0d]", k),      co[k], m_cout[k]);
      chk($sformatf("cyc.ovf[%0d]", k),       of[k], m_ovf[k]);
    end
  end

  task automatic start_op(input int k, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic ts, input logic tc);
    a = ta; b = tbv; sub = ts; cin = tc; iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(input int k);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
  endtask

  task automatic run_lit(input string nm, input int k, input logic [7:0] ta, input logic [7:0] tbv,
                         input logic ts, input logic tc, input int elat,
                         input logic [7:0] es, input logic ec, input logic ev);
    int lat;
    chk({nm, ".in_ready"}, ir[k], 1);
    start_op(k, ta, tbv, ts, tc);
    wait_done(k, lat);
    chk({nm, ".latency"}, lat, elat);
    chk({nm, ".sum"}, sm[k], es);
    chk({nm, ".cout"}, co[k], ec);
    chk({nm, ".ovf"}, of[k], ev);
    handshake(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; iv = '0; ordy = '0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", ir, 3'b111);
    chk("reset.out_valid", ov, 0);
    chk("reset.busy", bz, 0);
    chk("reset.cout", co, 0);
    chk("reset.ovf", of, 0);
    chk("reset.sum0", sm[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_lit("add_zero",  0, 8'h00, 8'h00, 1'b0, 1'b0, 8, 8'h00, 1'b0, 1'b0);
    run_lit("add_wrap",  0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 8'h00, 1'b1, 1'b0);
    run_lit("add_ovf",   0, 8'h7F, 8'h01, 1'b0, 1'b0, 8, 8'h80, 1'b0, 1'b1);
    run_lit("add_cin",   0, 8'h10, 8'h20, 1'b0, 1'b1, 8, 8'h31, 1'b0, 1'b0);
    run_lit("sub_neg",   0, 8'h05, 8'h07, 1'b1, 1'b0, 8, 8'hFE, 1'b0, 1'b0);
    run_lit("sub_ovf",   0, 8'h80, 8'h01, 1'b1, 1'b0, 8, 8'h7F, 1'b1, 1'b1);
    run_lit("sub_cin1",  0, 8'h80, 8'h01, 1'b1, 1'b1, 8, 8'h7F, 1'b1, 1'b1);
    run_lit("bpc4_full", 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 2, 8'hFF, 1'b1, 1'b0);
    run_lit("bpc8_full", 2, 8'hFF, 8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b1, 1'b0);
    run_lit("bpc8_sub",  2, 8'h05, 8'h07, 1'b1, 1'b0, 1, 8'hFE, 1'b0, 1'b0);

    // Back-pressure with operand pulses that must be ignored.
    start_op(0, 8'h33, 8'h44, 1'b0, 1'b0);
    wait_done(0, lat);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); iv[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp.out_valid", ov[0], 1);
      chk("bp.in_ready", ir[0], 0);
      chk("bp.sum", sm[0], 8'h77);
      chk("bp.cout", co[0], 0);
      chk("bp.ovf", of[0], 0);
    end
    iv[0] = 1'b0;
    handshake(0);
    run_lit("after_bp", 0, 8'h01, 8'h01, 1'b0, 1'b0, 8, 8'h02, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a computation.
    start_op(0, 8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", ov[0], 0);
    chk("arst.busy", bz[0], 0);
    chk("arst.sum", sm[0], 8'h00);
    chk("arst.in_ready", ir[0], 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_lit("post_rst", 0, 8'h01, 8'h02, 1'b0, 1'b0, 8, 8'h03, 1'b0, 1'b0);

    // Randomized operations across all three configurations.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, NI - 1);
      start_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom); b = 8'($urandom); iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
      end
      wait_done(k, lat);
      chk("rand.done", ov[k], 1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      handshake(k);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
